// File: rtl/kernel_weight_loader.sv
// Writer side of the packed floating-kernel bus: assembles weight beats into a
// shadow buffer and publishes the completed kernel while the engine is idle.
module kernel_weight_loader #(
  parameter int unsigned WEIGHTS_WIDTH  = 4,
  parameter int unsigned KERNEL_SIZE    = 3,
  parameter int unsigned WEIGHTS_NUMBER = KERNEL_SIZE * KERNEL_SIZE,
  parameter int unsigned DATA_WIDTH     = 32
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  clk_en_i,
  input  logic                                  clear_i,
  input  logic [DATA_WIDTH-1:0]                 wr_data_i,
  input  logic                                  wr_valid_i,
  input  logic                                  wr_last_i,
  output logic                                  wr_ready_o,
  input  logic                                  kernel_busy_i,
  output logic [WEIGHTS_NUMBER*WEIGHTS_WIDTH-1:0] floating_kernel_o,
  output logic                                  kernel_valid_o,
  output logic                                  kernel_update_o,
  output logic                                  error_o
);

  localparam int unsigned WPB    = DATA_WIDTH / WEIGHTS_WIDTH;
  localparam int unsigned NBEATS = (WEIGHTS_NUMBER + WPB - 1) / WPB;
  localparam int unsigned KW     = WEIGHTS_NUMBER * WEIGHTS_WIDTH;
  localparam int unsigned SW     = NBEATS * DATA_WIDTH;
  localparam int unsigned CW     = $clog2(NBEATS + 1);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN, PENDING} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   shadow_q, shadow_d;
  logic [KW-1:0]   kernel_q, kernel_d;
  logic            kvalid_q, kvalid_d;
  logic            update_q, update_d;
  logic            error_q, error_d;
  logic            wr_en;
  logic [CW-1:0]   wr_idx;
  logic            accept;

  assign wr_ready_o        = clk_en_i && !clear_i && (state_q != PENDING);
  assign accept            = wr_valid_i && wr_ready_o;
  assign floating_kernel_o = kernel_q;
  assign kernel_valid_o    = kvalid_q;
  assign kernel_update_o   = update_q && clk_en_i;
  assign error_o           = error_q;

  // Next-state: clear has priority; a disabled clock freezes everything but the pulse.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    kernel_d = kernel_q;
    kvalid_d = kvalid_q;
    update_d = 1'b0;
    error_d  = error_q;
    wr_en    = 1'b0;
    wr_idx   = cnt_q;
    if (clk_en_i) begin
      if (clear_i) begin
        state_d = IDLE;
        cnt_d   = '0;
        error_d = 1'b0;
      end else begin
        case (state_q)
          IDLE: if (accept) begin
            wr_en  = 1'b1;
            wr_idx = '0;
            if (wr_last_i) begin
              cnt_d = '0;
              if (NBEATS == 1) state_d = PENDING;
              else             error_d = 1'b1;
            end else begin
              cnt_d   = CW'(1);
              state_d = FILL;
            end
          end
          FILL: if (accept) begin
            wr_en = 1'b1;
            if (cnt_q >= CW'(NBEATS - 1)) begin
              cnt_d = '0;
              if (wr_last_i) begin
                state_d = PENDING;
              end else begin
                error_d = 1'b1;
                state_d = DRAIN;
              end
            end else if (wr_last_i) begin
              error_d = 1'b1;
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
          DRAIN: if (accept && wr_last_i) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
          PENDING: if (!kernel_busy_i) begin
            kernel_d = shadow_q[KW-1:0];
            kvalid_d = 1'b1;
            update_d = 1'b1;
            state_d  = IDLE;
          end
          default: state_d = IDLE;
        endcase
      end
    end
    for (int b = 0; b < int'(NBEATS); b++) begin
      if (wr_en && (wr_idx == CW'(b))) shadow_d[b*DATA_WIDTH +: DATA_WIDTH] = wr_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      kernel_q <= '0;
      kvalid_q <= 1'b0;
      update_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      kernel_q <= kernel_d;
      kvalid_q <= kvalid_d;
      update_q <= update_d;
      error_q  <= error_d;
    end
  end

endmodule

// File: doc/kernel_weight_loader.md
Name: kernel_weight_loader

Overview:
- Writer side of the packed floating-kernel bus that the per-group floating kernel lookup reads.
- Accepts kernel weights as a valid/ready word stream from the configuration/DMA path and assembles them into a shadow buffer.
- Atomically publishes the completed kernel as the active packed vector, only while the downstream engine is not mid-event.
- One instance per filter group.

Parameters:
- WEIGHTS_WIDTH, 4, bits per weight.
- KERNEL_SIZE, 3, kernel edge length.
- WEIGHTS_NUMBER, KERNEL_SIZE*KERNEL_SIZE, weights per kernel.
- DATA_WIDTH, 32, input word width; must be a multiple of WEIGHTS_WIDTH.
- WPB (derived), DATA_WIDTH/WEIGHTS_WIDTH, weights per beat (8).
- NBEATS (derived), ceil(WEIGHTS_NUMBER/WPB), beats per kernel (2).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-high.
- clk_en_i  in  1  when low: no state, counter or register updates, and wr_ready_o=0.
- clear_i  in  1  synchronous abort of any fill in progress; the active kernel is kept.
- wr_data_i  in  DATA_WIDTH  weight word.
- wr_valid_i  in  1  word valid.
- wr_last_i  in  1  marks the final word of a kernel.
- wr_ready_o  out  1  word accepted when wr_valid_i && wr_ready_o.
- kernel_busy_i  in  1  downstream engine is processing an event; the kernel must not change.
- floating_kernel_o  out  WEIGHTS_NUMBER*WEIGHTS_WIDTH  active packed kernel.
- kernel_valid_o  out  1  at least one kernel has been published since reset.
- kernel_update_o  out  1  one-cycle pulse in the cycle after a publish edge.
- error_o  out  1  sticky framing error; cleared only by clear_i or reset.

Behaviour:
- Reset (async, rst_i=1):
  - State IDLE; beat counter 0.
  - Shadow buffer and floating_kernel_o all zero.
  - kernel_valid_o, kernel_update_o, error_o = 0.
- Packing:
  - Beat k, slot i (bits [(i+1)*WEIGHTS_WIDTH-1 : i*WEIGHTS_WIDTH]) carries weight j = k*WPB + i.
  - Weight j lands at floating_kernel_o[(j+1)*WEIGHTS_WIDTH-1 : j*WEIGHTS_WIDTH], with j = x + y*KERNEL_SIZE.
  - Slots with j >= WEIGHTS_NUMBER are ignored.
- wr_ready_o = clk_en_i && !clear_i && state in {IDLE, FILL, DRAIN}.
- IDLE:
  - Accepted beat is written to shadow beat 0; counter becomes 1.
  - Next state FILL, or PENDING if NBEATS=1 and wr_last_i=1.
- FILL:
  - Accepted beat is written to shadow beat[counter]; counter increments.
  - wr_last_i=1 on beat NBEATS-1: go to PENDING; counter becomes 0.
  - wr_last_i=1 before beat NBEATS-1: error_o=1, shadow discarded (not published), go to IDLE, counter 0.
  - wr_last_i=0 on beat NBEATS-1: error_o=1, go to DRAIN.
- DRAIN:
  - Accepted beats are discarded.
  - Beat with wr_last_i=1 returns to IDLE with counter 0.
- PENDING:
  - wr_ready_o=0.
  - On each enabled edge with kernel_busy_i=0: floating_kernel_o <= shadow, kernel_valid_o <= 1, kernel_update_o=1 in the following cycle, go to IDLE.
  - kernel_busy_i=1 holds PENDING indefinitely; floating_kernel_o stays unchanged.
- Latency: last beat accepted at edge N gives the earliest publish at edge N+1. The new kernel is visible from cycle N+1 onward, with the update pulse in that same cycle.
- A new fill may start in the cycle after publish.
- clear_i (enabled edge):
  - Takes priority over all transitions; go to IDLE, counter 0, error_o=0.
  - Shadow contents are don't-care; floating_kernel_o and kernel_valid_o are untouched.
  - Clear in PENDING drops the pending kernel.
- clk_en_i=0:
  - Freezes all state.
  - kernel_update_o is forced to 0 while clk_en_i=0; a pulse is never stretched.
- Reset mid-fill or mid-PENDING: everything returns to reset values, including floating_kernel_o.

Test Plan:
- Basic load:
  - Stimulus: kernel_busy_i=0, beats 0x76543210 then 0x0000000F with last.
  - Response: floating_kernel_o=36'hF76543210 one edge after the last beat, kernel_update_o single pulse, kernel_valid_o=1, error_o=0.
- Busy hold:
  - Stimulus: same load with kernel_busy_i=1 for 5 cycles after the last beat.
  - Response: wr_ready_o=0 and floating_kernel_o unchanged (previous value) for 5 cycles; update on the first edge with busy=0.
- Early last:
  - Stimulus: beat 0x11111111 with wr_last_i=1.
  - Response: error_o=1, state IDLE, floating_kernel_o unchanged, no update pulse; a subsequent clean 2-beat load publishes correctly with error_o still 1.
- Missing last:
  - Stimulus: 4 beats with last only on the 4th.
  - Response: error_o=1, beats 3-4 discarded, no publish, ready high throughout.
- Clear in PENDING:
  - Stimulus: load with busy=1, pulse clear_i.
  - Response: error_o=0, no publish after busy falls, active kernel retains its prior value.
- Reset / clock-enable:
  - Stimulus: assert rst_i mid-fill.
  - Response: all outputs immediately zero.
  - Stimulus: clk_en_i=0 during a valid beat.
  - Response: wr_ready_o=0, counter frozen, no beat taken.
